mag_share_arbiter: RTL

- Shares one |Re|+|Im| magnitude unit (2-cycle latency, no backpressure) between two OFDM Rx requesters, e.g. the timing-sync correlator (port 0) and the channel/peak estimator (port 1).
- Grants the unit in bursts with round-robin fairness and forwards the granted sample stream to the unit.
- Tags every in-flight sample so each magnitude result returns to the requester that issued it.

---
 rtl/mag_share_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mag_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mag_share_arbiter
// Description : Round-robin burst arbiter sharing one |Re|+|Im| unit between
//               two requesters, with tagged return routing of results.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_share_arbiter #(
    parameter int DW        = 21,
    parameter int MAG_LAT   = 2,
    parameter int MAX_BURST = 64
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req0,
    input  logic          Req1,
    input  logic          Last0,
    input  logic          Last1,
    input  logic          DataEn0,
    input  logic          DataEn1,
    input  logic [DW-1:0] Re0,
    input  logic [DW-1:0] Im0,
    input  logic [DW-1:0] Re1,
    input  logic [DW-1:0] Im1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          AbsEn0,
    output logic          AbsEn1,
    output logic [DW:0]   Abs0,
    output logic [DW:0]   Abs1,
    output logic          MagDataEnable,
    output logic [DW-1:0] MagDataRe,
    output logic [DW-1:0] MagDataIm,
    input  logic          MagAbsoluteEnable,
    input  logic [DW:0]   MagAbsolute,
    output logic [1:0]    Drop,
    output logic          TagErr
);

    localparam int       CW     = $clog2(MAX_BURST + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_ptr;
    logic          w_ptr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc;
    logic          w_last;
    logic          w_req_g;
    logic          w_end;
    logic [DW-1:0] w_re;
    logic [DW-1:0] w_im;

    logic [MAG_LAT:0] r_tag_v;
    logic [MAG_LAT:0] r_tag_p;
    logic             w_hit;

    logic          r_mag_en;
    logic [DW-1:0] r_mag_re;
    logic [DW-1:0] r_mag_im;
    logic          r_absen0;
    logic          r_absen1;
    logic [DW:0]   r_abs0;
    logic [DW:0]   r_abs1;
    logic [1:0]    r_drop;
    logic          r_tagerr;

    assign w_gnt0  = (r_state == S_GNT0);
    assign w_gnt1  = (r_state == S_GNT1);
    assign w_acc   = (DataEn0 & w_gnt0) | (DataEn1 & w_gnt1);
    assign w_last  = w_gnt1 ? Last1 : Last0;
    assign w_req_g = w_gnt1 ? Req1  : Req0;
    assign w_re    = w_gnt1 ? Re1   : Re0;
    assign w_im    = w_gnt1 ? Im1   : Im0;

    // Last and the MAX_BURST-th sample coinciding still yield one end.
    assign w_end = (w_gnt0 | w_gnt1) &
                   (~w_req_g | (w_acc & (w_last | (r_cnt == CW'(MAX_BURST - 1)))));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (Req0 && Req1)
                    w_state_nxt = r_ptr ? S_GNT1 : S_GNT0;
                else if (Req0)
                    w_state_nxt = S_GNT0;
                else if (Req1)
                    w_state_nxt = S_GNT1;
            end
            S_GNT0, S_GNT1: begin
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_gnt0;
                    w_cnt_nxt   = '0;
                end else if (w_acc && (r_cnt != CW'(MAX_BURST))) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Gnt0 = w_gnt0;
        Gnt1 = w_gnt1;
    end

    // The last tag stage is aligned with the unit's AbsoluteEnable.
    assign w_hit = MagAbsoluteEnable & r_tag_v[MAG_LAT];

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_mag_en <= 1'b0;
            r_mag_re <= '0;
            r_mag_im <= '0;
            r_tag_v  <= '0;
            r_tag_p  <= '0;
            r_absen0 <= 1'b0;
            r_absen1 <= 1'b0;
            r_abs0   <= '0;
            r_abs1   <= '0;
            r_drop   <= '0;
            r_tagerr <= 1'b0;
        end else begin
            r_mag_en   <= w_acc;
            r_mag_re   <= w_acc ? w_re : '0;
            r_mag_im   <= w_acc ? w_im : '0;
            r_tag_v[0] <= w_acc;
            r_tag_p[0] <= w_gnt1;
            for (int i = 1; i <= MAG_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
            r_absen0 <= w_hit & ~r_tag_p[MAG_LAT];
            r_absen1 <= w_hit &  r_tag_p[MAG_LAT];
            r_abs0   <= (w_hit & ~r_tag_p[MAG_LAT]) ? MagAbsolute : '0;
            r_abs1   <= (w_hit &  r_tag_p[MAG_LAT]) ? MagAbsolute : '0;
            r_drop   <= {DataEn1 & ~w_gnt1, DataEn0 & ~w_gnt0};
            r_tagerr <= MagAbsoluteEnable & ~r_tag_v[MAG_LAT];
        end
    end

    assign MagDataEnable = r_mag_en;
    assign MagDataRe     = r_mag_re;
    assign MagDataIm     = r_mag_im;
    assign AbsEn0        = r_absen0;
    assign AbsEn1        = r_absen1;
    assign Abs0          = r_abs0;
    assign Abs1          = r_abs1;
    assign Drop          = r_drop;
    assign TagErr        = r_tagerr;

endmodule
`default_nettype wire
